// File: rtl/siso_xfer_ctrl_if.sv
// Handshake and serial-chain signals between the transfer controller and its
// producer/consumer plus the attached SISO chain.
interface siso_xfer_ctrl_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] din;
  logic             ser_out;
  logic             shift_en;
  logic             ser_in;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             dout_ready;
  logic             busy;

  modport master (
    input  start_valid, din, ser_in, dout_ready,
    output start_ready, ser_out, shift_en, dout, dout_valid, busy
  );

  modport slave (
    output start_valid, din, ser_in, dout_ready,
    input  start_ready, ser_out, shift_en, dout, dout_valid, busy
  );
endinterface

// File: rtl/siso_xfer_ctrl.sv
// Serialises a parallel word MSB-first through a DEPTH-stage SISO chain and
// recovers it from the chain output, presenting the result on valid/ready.
module siso_xfer_ctrl #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  siso_xfer_ctrl_if.master   bus
);

  localparam int unsigned XFER_LEN = WIDTH + DEPTH;
  localparam int unsigned CW       = $clog2(XFER_LEN + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] tx;
  logic [WIDTH-1:0] rx;
  logic [WIDTH-1:0] rx_next_c;
  logic             capture_c;

  // Capture begins once the first driven bit has crossed the whole chain.
  assign capture_c = (cnt >= CW'(DEPTH));
  assign rx_next_c = (rx << 1) | WIDTH'(bus.ser_in);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      cnt             <= '0;
      tx              <= '0;
      rx              <= '0;
      bus.start_ready <= 1'b1;
      bus.ser_out     <= 1'b0;
      bus.shift_en    <= 1'b0;
      bus.dout        <= '0;
      bus.dout_valid  <= 1'b0;
      bus.busy        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start_valid) begin
            state           <= SHIFT;
            cnt             <= '0;
            tx              <= bus.din << 1;
            rx              <= '0;
            bus.ser_out     <= bus.din[WIDTH-1];
            bus.shift_en    <= 1'b1;
            bus.start_ready <= 1'b0;
            bus.busy        <= 1'b1;
          end
        end

        // tx shifts in zeros, so the flush cycles drive 0 without extra logic.
        SHIFT: begin
          cnt         <= cnt + CW'(1);
          tx          <= tx << 1;
          bus.ser_out <= tx[WIDTH-1];
          if (capture_c) begin
            rx <= rx_next_c;
          end
          if (cnt == CW'(XFER_LEN - 1)) begin
            state          <= DONE;
            bus.dout       <= rx_next_c;
            bus.dout_valid <= 1'b1;
            bus.shift_en   <= 1'b0;
            bus.ser_out    <= 1'b0;
          end
        end

        DONE: begin
          if (bus.dout_ready) begin
            state           <= IDLE;
            bus.dout_valid  <= 1'b0;
            bus.start_ready <= 1'b1;
            bus.busy        <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_siso_xfer_ctrl.sv
// Self-checking bench for siso_xfer_ctrl driving a behavioural 4-stage SISO
// chain; expected words and bit streams come from the transfer rules directly.
module tb_siso_xfer_ctrl;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned XLEN  = WIDTH + DEPTH;

  logic clk = 1'b0;
  logic rst_n;

  siso_xfer_ctrl_if #(.WIDTH(WIDTH)) bus ();

  siso_xfer_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // SISO chain model; never reset, so it starts and keeps stale contents.
  logic [DEPTH-1:0] chain = 4'b1011;
  assign bus.ser_in = chain[DEPTH-1];
  always @(posedge clk) begin
    if (bus.shift_en) chain <= {chain[DEPTH-2:0], bus.ser_out};
  end

  int passed = 0;
  int total  = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one transfer up to the first DOUT_VALID sample, recording the stream.
  task automatic do_xfer(input logic [WIDTH-1:0] d, output logic [XLEN-1:0] seq,
                         output int shifts, output int lat, output bit to);
    int n;
    to = 1'b0; seq = '0; shifts = 0; lat = 0; n = 0;
    while (bus.start_ready !== 1'b1 && n < 50) begin tick(); n++; end
    if (n >= 50) begin to = 1'b1; return; end
    bus.din = d; bus.start_valid = 1'b1;
    tick();
    bus.start_valid = 1'b0;
    lat = 1;
    while (bus.dout_valid !== 1'b1 && lat < 60) begin
      if (bus.shift_en === 1'b1) begin seq = {seq[XLEN-2:0], bus.ser_out}; shifts++; end
      tick(); lat++;
    end
    if (lat >= 60) to = 1'b1;
  endtask

  task automatic test_reset();
    logic [12:0] obs;
    rst_n = 1'b0; bus.start_valid = 1'b0; bus.din = '0; bus.dout_ready = 1'b1;
    repeat (3) tick();
    obs = {bus.start_ready, bus.ser_out, bus.shift_en, bus.dout_valid, bus.busy, bus.dout};
    total++;
    if (obs !== {5'b10000, 8'h00}) $display("FAIL reset_outputs: got %b expected %b", obs, {5'b10000, 8'h00});
    else passed++;
    rst_n = 1'b1;
    repeat (2) tick();
    obs = {bus.start_ready, bus.ser_out, bus.shift_en, bus.dout_valid, bus.busy, bus.dout};
    total++;
    if (obs !== {5'b10000, 8'h00}) $display("FAIL idle_after_reset: got %b expected %b", obs, {5'b10000, 8'h00});
    else passed++;
  endtask

  task automatic test_basic();
    logic [XLEN-1:0] seq; int sh, lat; bit to;
    do_xfer(8'hA5, seq, sh, lat, to);
    total++;
    if (to !== 1'b0) $display("FAIL basic_timeout: got %0b expected 0", to); else passed++;
    total++;
    if (seq !== 12'b1010_0101_0000) $display("FAIL basic_ser_seq: got %b expected %b", seq, 12'b1010_0101_0000);
    else passed++;
    total++;
    if (sh !== XLEN) $display("FAIL basic_shift_count: got %0d expected %0d", sh, XLEN); else passed++;
    total++;
    if (lat !== XLEN + 1) $display("FAIL basic_latency: got %0d expected %0d", lat, XLEN + 1); else passed++;
    total++;
    if (bus.dout !== 8'hA5) $display("FAIL basic_dout: got %h expected a5", bus.dout); else passed++;
    tick();
    total++;
    if ({bus.start_ready, bus.dout_valid, bus.dout} !== {2'b10, 8'hA5})
      $display("FAIL basic_return_idle: got %b expected %b", {bus.start_ready, bus.dout_valid, bus.dout}, {2'b10, 8'hA5});
    else passed++;
  endtask

  task automatic test_backpressure();
    logic [XLEN-1:0] seq; int sh, lat; bit to;
    logic [11:0] obs;
    bus.dout_ready = 1'b0;
    do_xfer(8'h3C, seq, sh, lat, to);
    total++;
    if ({to, bus.dout} !== {1'b0, 8'h3C}) $display("FAIL bp_first_dout: got to=%0b dout=%h expected to=0 dout=3c", to, bus.dout);
    else passed++;
    for (int i = 0; i < 5; i++) begin
      tick();
      obs = {bus.dout_valid, bus.shift_en, bus.start_ready, bus.busy, bus.dout};
      total++;
      if (obs !== {4'b1001, 8'h3C}) $display("FAIL bp_hold_%0d: got %b expected %b", i, obs, {4'b1001, 8'h3C});
      else passed++;
    end
    bus.dout_ready = 1'b1;
    tick();
    total++;
    if ({bus.dout_valid, bus.start_ready, bus.busy, bus.dout} !== {3'b010, 8'h3C})
      $display("FAIL bp_release: got %b expected %b", {bus.dout_valid, bus.start_ready, bus.busy, bus.dout}, {3'b010, 8'h3C});
    else passed++;
  endtask

  task automatic test_ignored_request();
    int n, bad;
    bus.din = 8'h01; bus.start_valid = 1'b1;
    tick();
    bus.din = 8'hFF;
    n = 0; bad = 0;
    while (bus.dout_valid !== 1'b1 && n < 60) begin
      if (bus.start_ready !== 1'b0) bad++;
      tick(); n++;
    end
    total++;
    if (n !== XLEN || bad !== 0) $display("FAIL ign_busy_window: got cycles=%0d ready_high=%0d expected cycles=%0d ready_high=0", n, bad, XLEN);
    else passed++;
    total++;
    if (bus.dout !== 8'h01) $display("FAIL ign_dout: got %h expected 01", bus.dout); else passed++;
    tick();
    total++;
    if ({bus.start_ready, bus.busy} !== 2'b10) $display("FAIL ign_idle_bubble: got %b expected 10", {bus.start_ready, bus.busy});
    else passed++;
    tick();
    bus.start_valid = 1'b0;
    n = 0;
    while (bus.dout_valid !== 1'b1 && n < 60) begin tick(); n++; end
    total++;
    if (bus.dout_valid !== 1'b1 || bus.dout !== 8'hFF) $display("FAIL ign_second_dout: got valid=%b dout=%h expected valid=1 dout=ff", bus.dout_valid, bus.dout);
    else passed++;
    tick();
  endtask

  task automatic test_reset_midop();
    logic [XLEN-1:0] seq; int sh, lat; bit to;
    logic [12:0] obs;
    bus.din = 8'hC3; bus.start_valid = 1'b1;
    tick();
    bus.start_valid = 1'b0;
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    obs = {bus.start_ready, bus.ser_out, bus.shift_en, bus.dout_valid, bus.busy, bus.dout};
    total++;
    if (obs !== {5'b10000, 8'hA5 ^ 8'hA5}) $display("FAIL midop_async_reset: got %b expected %b", obs, {5'b10000, 8'h00});
    else passed++;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    do_xfer(8'h5A, seq, sh, lat, to);
    total++;
    if ({to, bus.dout, seq} !== {1'b0, 8'h5A, 8'h5A, 4'h0})
      $display("FAIL midop_next_xfer: got to=%0b dout=%h seq=%b expected to=0 dout=5a seq=%b", to, bus.dout, seq, {8'h5A, 4'h0});
    else passed++;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] vals [3];
    logic [WIDTH-1:0] got [$];
    int vcyc [$];
    int idx, n, idle_cnt;
    bit acc;
    vals[0] = 8'h00; vals[1] = 8'hFF; vals[2] = 8'h81;
    idx = 0; n = 0; idle_cnt = 0;
    bus.dout_ready = 1'b1; bus.din = vals[0]; bus.start_valid = 1'b1;
    while (got.size() < 3 && n < 200) begin
      if (bus.busy === 1'b0 && got.size() >= 1) idle_cnt++;
      if (bus.dout_valid === 1'b1) begin got.push_back(bus.dout); vcyc.push_back(n); end
      acc = (bus.start_ready === 1'b1) && bus.start_valid;
      if (got.size() < 3) begin
        tick(); n++;
        if (acc) begin
          idx++;
          if (idx < 3) bus.din = vals[idx]; else bus.start_valid = 1'b0;
        end
      end
    end
    bus.start_valid = 1'b0;
    total++;
    if (got.size() !== 3) $display("FAIL b2b_count: got %0d expected 3", got.size()); else passed++;
    for (int i = 0; i < got.size(); i++) begin
      total++;
      if (got[i] !== vals[i]) $display("FAIL b2b_dout_%0d: got %h expected %h", i, got[i], vals[i]); else passed++;
    end
    for (int i = 1; i < vcyc.size(); i++) begin
      total++;
      if (vcyc[i] - vcyc[i-1] !== XLEN + 2)
        $display("FAIL b2b_period_%0d: got %0d expected %0d", i, vcyc[i] - vcyc[i-1], XLEN + 2);
      else passed++;
    end
    total++;
    if (idle_cnt !== 2) $display("FAIL b2b_idle_cycles: got %0d expected 2", idle_cnt); else passed++;
    tick();
  endtask

  task automatic test_random();
    logic [XLEN-1:0] seq; int sh, lat, hold, gap; bit to;
    logic [WIDTH-1:0] d;
    for (int t = 0; t < 20; t++) begin
      d = WIDTH'($urandom);
      hold = $urandom_range(0, 3);
      gap = $urandom_range(0, 2);
      repeat (gap) tick();
      bus.dout_ready = (hold == 0);
      do_xfer(d, seq, sh, lat, to);
      total++;
      if ({to, bus.dout} !== {1'b0, d}) $display("FAIL rand_dout_%0d: got to=%0b dout=%h expected to=0 dout=%h", t, to, bus.dout, d);
      else passed++;
      total++;
      if (seq !== {d, 4'h0} || sh !== XLEN || lat !== XLEN + 1)
        $display("FAIL rand_stream_%0d: got seq=%b shifts=%0d lat=%0d expected seq=%b shifts=%0d lat=%0d",
                 t, seq, sh, lat, {d, 4'h0}, XLEN, XLEN + 1);
      else passed++;
      if (hold > 0) begin
        repeat (hold) tick();
        total++;
        if ({bus.dout_valid, bus.dout} !== {1'b1, d}) $display("FAIL rand_hold_%0d: got %b expected %b", t, {bus.dout_valid, bus.dout}, {1'b1, d});
        else passed++;
        bus.dout_ready = 1'b1;
      end
      tick();
      total++;
      if (bus.dout_valid !== 1'b0) $display("FAIL rand_release_%0d: got %b expected 0", t, bus.dout_valid); else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_ignored_request();
    test_reset_midop();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
